// File: rtl/pwm_regs_pkg.sv
// rtl/pwm_regs_pkg.sv - PWM register map, ctrl bit indices and fade FSM states
package pwm_regs_pkg;

  localparam logic [7:0] REG_EN_OUT_7_0  = 8'h00;
  localparam logic [7:0] REG_EN_OUT_15_8 = 8'h01;
  localparam logic [7:0] REG_EN_PWM_7_0  = 8'h02;
  localparam logic [7:0] REG_EN_PWM_15_8 = 8'h03;
  localparam logic [7:0] REG_DUTY        = 8'h04;
  localparam logic [7:0] REG_TARGET      = 8'h05;
  localparam logic [7:0] REG_STEP        = 8'h06;
  localparam logic [7:0] REG_PERIOD_LO   = 8'h07;
  localparam logic [7:0] REG_PERIOD_HI   = 8'h08;
  localparam logic [7:0] REG_CTRL        = 8'h09;

  localparam int CTRL_START  = 0;
  localparam int CTRL_BOUNCE = 1;

  typedef enum logic [1:0] {IDLE, WAIT, STEP, DONE} fade_state_t;

endpackage

// File: rtl/fade_prescaler.sv
// rtl/fade_prescaler.sv - loadable fade period down-counter; a zero period behaves as one
module fade_prescaler #(
  parameter int PRESCALE_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic                  en,
  input  logic [PRESCALE_W-1:0] period,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= (period == '0) ? PRESCALE_W'(1) : period;
    end else if (en && (count > PRESCALE_W'(1))) begin
      count <= count - PRESCALE_W'(1);
    end
  end

  assign tick = (count == PRESCALE_W'(1));

endmodule

// File: rtl/pwm_fade_sequencer.sv
// rtl/pwm_fade_sequencer.sv - PWM config registers plus duty-cycle fade sequencer
// Optional FADE_BOUNCE_EN: ctrl bounce bit makes the fade ping-pong between origin and target.
module pwm_fade_sequencer
  import pwm_regs_pkg::*;
#(
  parameter int PRESCALE_W = 16,
  parameter int ADDR_W     = 7,
  parameter int DATA_W     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              spi_wr_valid,
  input  logic [ADDR_W-1:0] spi_wr_addr,
  input  logic [DATA_W-1:0] spi_wr_data,
  output logic [7:0]        en_reg_out_7_0,
  output logic [7:0]        en_reg_out_15_8,
  output logic [7:0]        en_reg_pwm_7_0,
  output logic [7:0]        en_reg_pwm_15_8,
  output logic [DATA_W-1:0] pwm_duty_cycle,
  output logic              fade_busy,
  output logic              fade_done
);

  fade_state_t state, next_state;

  logic [DATA_W-1:0]     target, step_size, step_eff, step_val;
  logic [7:0]            period_lo, period_hi;
  logic [PRESCALE_W-1:0] period;
  logic [DATA_W:0]       sum, diff;
  logic                  wr_ctrl, wr_duty, start, load, do_step, tick;
`ifdef FADE_BOUNCE_EN
  logic                  bounce, swap;
  logic [DATA_W-1:0]     origin;
`endif

  assign wr_ctrl = spi_wr_valid && (spi_wr_addr == ADDR_W'(REG_CTRL));
  assign wr_duty = spi_wr_valid && (spi_wr_addr == ADDR_W'(REG_DUTY));
  assign start   = wr_ctrl && spi_wr_data[CTRL_START];
  assign period  = PRESCALE_W'({period_hi, period_lo});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_reg_out_7_0  <= '0;
      en_reg_out_15_8 <= '0;
      en_reg_pwm_7_0  <= '0;
      en_reg_pwm_15_8 <= '0;
      step_size       <= '0;
      period_lo       <= '0;
      period_hi       <= '0;
`ifdef FADE_BOUNCE_EN
      bounce          <= 1'b0;
`endif
    end else if (spi_wr_valid) begin
      case (spi_wr_addr)
        ADDR_W'(REG_EN_OUT_7_0):  en_reg_out_7_0  <= 8'(spi_wr_data);
        ADDR_W'(REG_EN_OUT_15_8): en_reg_out_15_8 <= 8'(spi_wr_data);
        ADDR_W'(REG_EN_PWM_7_0):  en_reg_pwm_7_0  <= 8'(spi_wr_data);
        ADDR_W'(REG_EN_PWM_15_8): en_reg_pwm_15_8 <= 8'(spi_wr_data);
        ADDR_W'(REG_STEP):        step_size       <= spi_wr_data;
        ADDR_W'(REG_PERIOD_LO):   period_lo       <= 8'(spi_wr_data);
        ADDR_W'(REG_PERIOD_HI):   period_hi       <= 8'(spi_wr_data);
`ifdef FADE_BOUNCE_EN
        ADDR_W'(REG_CTRL):        bounce          <= spi_wr_data[CTRL_BOUNCE];
`endif
        default: ;
      endcase
    end
  end

  // One extra bit catches carry/borrow so the step saturates at target instead of wrapping.
  always_comb begin
    step_eff = (step_size == '0) ? DATA_W'(1) : step_size;
    sum      = {1'b0, pwm_duty_cycle} + {1'b0, step_eff};
    diff     = {1'b0, pwm_duty_cycle} - {1'b0, step_eff};
    if (pwm_duty_cycle < target) begin
      step_val = (sum >= {1'b0, target}) ? target : sum[DATA_W-1:0];
    end else begin
      step_val = (diff[DATA_W] || (diff[DATA_W-1:0] <= target)) ? target : diff[DATA_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_duty_cycle <= '0;
      target         <= '0;
`ifdef FADE_BOUNCE_EN
      origin         <= '0;
`endif
    end else begin
      if (wr_duty) begin
        pwm_duty_cycle <= spi_wr_data;
      end else if (do_step) begin
        pwm_duty_cycle <= step_val;
      end
      if (spi_wr_valid && (spi_wr_addr == ADDR_W'(REG_TARGET))) begin
        target <= spi_wr_data;
      end
`ifdef FADE_BOUNCE_EN
      else if (swap) begin
        target <= origin;
      end
      if (start) begin
        origin <= pwm_duty_cycle;
      end else if (swap) begin
        origin <= target;
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    load       = 1'b0;
    do_step    = 1'b0;
`ifdef FADE_BOUNCE_EN
    swap       = 1'b0;
`endif
    case (state)
      IDLE: ;
      WAIT: if (tick) next_state = STEP;
      STEP: begin
        do_step = 1'b1;
        if (step_val == target) begin
          next_state = DONE;
        end else begin
          next_state = WAIT;
          load       = 1'b1;
        end
      end
      DONE: begin
        next_state = IDLE;
`ifdef FADE_BOUNCE_EN
        if (bounce) begin
          next_state = WAIT;
          load       = 1'b1;
          swap       = 1'b1;
        end
`endif
      end
      default: next_state = IDLE;
    endcase
    // SPI ctrl and duty writes override whatever the sequencer planned this cycle.
    if (wr_ctrl || wr_duty) begin
      do_step    = 1'b0;
      load       = start;
      next_state = start ? WAIT : IDLE;
`ifdef FADE_BOUNCE_EN
      swap       = 1'b0;
`endif
    end
  end

  fade_prescaler #(.PRESCALE_W(PRESCALE_W)) u_prescaler (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (load),
    .en     (state == WAIT),
    .period (period),
    .tick   (tick)
  );

  assign fade_busy = (state == WAIT) || (state == STEP);
  assign fade_done = (state == DONE);

endmodule
